// File: rtl/rps_pkg.sv
// ============================================================================
// rps_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the rps_arbiter slice.
//
// Contents:
//   DEFAULT_N        default number of requesters (power of two, >= 2)
//   DEFAULT_MAX_HOLD default hold limit in cycles (0 = unlimited)
//   state_t          arbiter FSM state: IDLE (no owner) / BUSY (owner held)
// ============================================================================
package rps_pkg;

    localparam int DEFAULT_N        = 4;
    localparam int DEFAULT_MAX_HOLD = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage : rps_pkg

// File: rtl/rps_pick.sv
// ============================================================================
// rps_pick
// ----------------------------------------------------------------------------
// Combinational rotating first-one finder. Scans the request vector starting
// at index 'start' and moving upward, wrapping modulo N. It ignores any
// request whose bit is set in 'exclude'.
//
// Parameters:
//   N        number of request lines (power of two, >= 2)
//
// Ports:
//   req      input  [N-1:0]          request lines
//   start    input  [$clog2(N)-1:0]  first index examined
//   exclude  input  [N-1:0]          requests masked out of the search
//   onehot   output [N-1:0]          one-hot winner, zero when none found
//   idx      output [$clog2(N)-1:0]  winner index, zero when none found
//   found    output                  a winner exists
// ============================================================================
module rps_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start,
    input  logic [N-1:0]         exclude,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);

    localparam int W = $clog2(N);

    logic [N-1:0] candidates;

    assign candidates = req & ~exclude;

    // Because N is a power of two, the W-bit sum start+i wraps modulo N on
    // its own. The first hit in scan order wins. Later hits are ignored
    // once 'found' is set.
    always_comb begin
        logic [W-1:0] pos;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = '0;
        for (int i = 0; i < N; i++) begin
            pos = start + W'(i);
            if (!found && candidates[pos]) begin
                found       = 1'b1;
                idx         = pos;
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule : rps_pick

// File: rtl/rps_arbiter.sv
// ============================================================================
// rps_arbiter
// ----------------------------------------------------------------------------
// N-way arbiter. It selects either round-robin or fixed-priority arbitration
// and has an optional hold limit. A granted owner keeps the grant while it
// requests. If it exceeds MAX_HOLD cycles while others wait, the grant is
// passed on. Grant outputs come straight from registers, so no combinational
// path runs from req to gnt.
//
// Parameters:
//   N          number of requesters (power of two, >= 2)
//   MAX_HOLD   maximum cycles an owner keeps the grant while others wait;
//              0 disables the limit
//
// Ports:
//   clock      input                   rising-edge clock
//   reset_n    input                   asynchronous active-low reset
//   en         input                   arbitration enable
//   req        input  [N-1:0]          request lines
//   mode       input                   0 = round-robin, 1 = fixed priority
//   gnt        output [N-1:0]          registered one-hot (or zero) grant
//   gnt_idx    output [$clog2(N)-1:0]  index of the granted requester
//   gnt_valid  output                  gnt is non-zero
//   ptr        output [$clog2(N)-1:0]  round-robin priority pointer
// ============================================================================
module rps_arbiter
    import rps_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic                 mode,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] ptr
);

    localparam int W         = $clog2(N);
    localparam int HOLD_W    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    state_t              state;
    state_t              next_state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_next;
    logic [N-1:0]        gnt_next;
    logic [W-1:0]        idx_next;
    logic                valid_next;
    logic [W-1:0]        ptr_next;

    logic                req_owner;
    logic                limit_hit;
    logic                rearb_limit;
    logic                take_new;

    logic [W-1:0]        pick_start;
    logic [N-1:0]        pick_exclude;
    logic [N-1:0]        pick_onehot;
    logic [W-1:0]        pick_idx;
    logic                pick_found;

    // gnt_idx always names the current owner while BUSY, so it serves as
    // the owner register. Outside BUSY its value is zero and unused.
    assign req_owner = req[gnt_idx];
    assign limit_hit = (MAX_HOLD > 0) && (hold_cnt == HOLD_W'(HOLD_LAST));

    // When the hold limit expires and the owner still requests, the owner
    // is masked out of the search. A hit then means someone else is waiting.
    // No hit means the owner stays.
    assign rearb_limit  = (state == BUSY) && req_owner && limit_hit;
    assign pick_exclude = rearb_limit ? gnt : '0;
    assign pick_start   = mode ? '0 : ptr;

    rps_pick #(
        .N (N)
    ) u_pick (
        .req     (req),
        .start   (pick_start),
        .exclude (pick_exclude),
        .onehot  (pick_onehot),
        .idx     (pick_idx),
        .found   (pick_found)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. 'take_new' marks cycles where the search winner
    // is loaded as a new owner. Disabling the block overrides everything.
    always_comb begin
        next_state = state;
        take_new   = 1'b0;
        if (!en) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        next_state = BUSY;
                        take_new   = 1'b1;
                    end
                end
                BUSY: begin
                    if (!req_owner) begin
                        if (pick_found) begin
                            take_new = 1'b1;
                        end else begin
                            next_state = IDLE;
                        end
                    end else if (limit_hit && pick_found) begin
                        take_new = 1'b1;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Output / datapath next values. A new grant clears the hold counter.
    // In round-robin mode it also moves the pointer just past the winner.
    // A kept grant advances the hold counter up to its saturation value.
    always_comb begin
        gnt_next   = gnt;
        idx_next   = gnt_idx;
        valid_next = gnt_valid;
        ptr_next   = ptr;
        hold_next  = hold_cnt;
        if (next_state == IDLE) begin
            gnt_next   = '0;
            idx_next   = '0;
            valid_next = 1'b0;
            hold_next  = '0;
        end else if (take_new) begin
            gnt_next   = pick_onehot;
            idx_next   = pick_idx;
            valid_next = 1'b1;
            hold_next  = '0;
            if (!mode) begin
                ptr_next = pick_idx + W'(1);
            end
        end else if ((MAX_HOLD > 0) && !limit_hit) begin
            hold_next = hold_cnt + HOLD_W'(1);
        end
    end

    // Output and bookkeeping registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            gnt       <= gnt_next;
            gnt_idx   <= idx_next;
            gnt_valid <= valid_next;
            ptr       <= ptr_next;
            hold_cnt  <= hold_next;
        end
    end

endmodule : rps_arbiter

// File: tb/tb_rps_arbiter.sv
// ============================================================================
// tb_rps_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for rps_arbiter (N=4, MAX_HOLD=4). It compares the DUT
// against a behavioural model of the arbitration rules. The model tracks the
// owner as an integer (-1 = none), along with the hold count and the pointer.
// The bench also makes directed constant checks for the canonical scenarios.
// ============================================================================
module tb_rps_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int W        = 2;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b1;
    logic         en      = 1'b0;
    logic         mode    = 1'b0;
    logic [N-1:0] req     = '0;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_idx;
    logic         gnt_valid;
    logic [W-1:0] ptr;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_owner = -1;
    int m_hold  = 0;
    int m_ptr   = 0;

    rps_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .req       (req),
        .mode      (mode),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .ptr       (ptr)
    );

    always #5 clock = ~clock;

    // first requester found scanning from the mode's start point, skipping excl
    function automatic int m_search(int excl);
        int start;
        start = mode ? 0 : m_ptr;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (start + i) % N;
            if (req[k] && k != excl) return k;
        end
        return -1;
    endfunction

    task automatic m_grant(int w);
        m_owner = w;
        m_hold  = 0;
        if (!mode) m_ptr = (w + 1) % N;
    endtask

    task automatic m_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
    endtask

    // one rising edge worth of arbitration rules
    task automatic m_clock();
        int w;
        if (!en) begin
            m_owner = -1;
            m_hold  = 0;
        end else if (m_owner < 0 || !req[m_owner]) begin
            w = m_search(-1);
            if (w >= 0) m_grant(w);
            else begin
                m_owner = -1;
                m_hold  = 0;
            end
        end else if (m_hold == MAX_HOLD - 1 && m_search(m_owner) >= 0) begin
            m_grant(m_search(m_owner));
        end else if (m_hold < MAX_HOLD - 1) begin
            m_hold = m_hold + 1;
        end
    endtask

    task automatic checkOutput(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkModel(string tag);
        checkOutput({tag, "_gnt"}, 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        checkOutput({tag, "_idx"}, 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        checkOutput({tag, "_valid"}, 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        checkOutput({tag, "_ptr"}, 32'(ptr), 32'(m_ptr));
    endtask

    // advance one clock, update the model, then sample just after the edge
    task automatic applyStimulus(string tag);
        @(posedge clock);
        m_clock();
        #1;
        checkModel(tag);
    endtask

    initial begin
        int saved_ptr;

        // asynchronous reset at start
        #2 reset_n = 1'b0;
        #1;
        m_reset();
        checkModel("reset");
        @(posedge clock);
        #1;
        checkModel("reset_hold");
        reset_n = 1'b1;

        // round-robin fairness with all requesters active
        en   = 1'b1;
        mode = 1'b0;
        req  = 4'b1111;
        for (int i = 0; i < 17; i++) begin
            applyStimulus("fair");
            checkOutput("fair_seq_gnt", 32'(gnt), 32'd1 << ((i / 4) % 4));
            checkOutput("fair_seq_ptr", 32'(ptr), 32'(((i / 4) + 1) % 4));
        end
        applyStimulus("fair_more");
        applyStimulus("fair_more");

        // asynchronous reset while BUSY, no clock edge in between
        reset_n = 1'b0;
        #1;
        checkOutput("midbusy_reset_gnt", 32'(gnt), 32'd0);
        checkOutput("midbusy_reset_valid", 32'(gnt_valid), 32'd0);
        checkOutput("midbusy_reset_ptr", 32'(ptr), 32'd0);
        m_reset();
        checkModel("midbusy_reset");
        #1 reset_n = 1'b1;

        // handoff without an idle bubble
        req = 4'b0011;
        applyStimulus("handoff_a");
        checkOutput("handoff_first", 32'(gnt), 32'b0001);
        req = 4'b0010;
        applyStimulus("handoff_b");
        checkOutput("handoff_next", 32'(gnt), 32'b0010);

        // fixed priority with hold limit
        en = 1'b0;
        applyStimulus("fixed_idle");
        en        = 1'b1;
        mode      = 1'b1;
        req       = 4'b1010;
        saved_ptr = m_ptr;
        for (int i = 0; i < 5; i++) begin
            applyStimulus("fixed");
            checkOutput("fixed_seq_gnt", 32'(gnt), (i < 4) ? 32'b0010 : 32'b1000);
            checkOutput("fixed_ptr_held", 32'(ptr), 32'(saved_ptr));
        end
        req = 4'b0010;
        applyStimulus("fixed_drop");
        checkOutput("fixed_drop_gnt", 32'(gnt), 32'b0010);
        checkOutput("fixed_drop_ptr", 32'(ptr), 32'(saved_ptr));

        // enable behaviour
        en = 1'b0;
        applyStimulus("en_idle");
        mode = 1'b0;
        en   = 1'b1;
        req  = 4'b0100;
        applyStimulus("en_owner2");
        checkOutput("en_owner2_gnt", 32'(gnt), 32'b0100);
        en = 1'b0;
        applyStimulus("en_off");
        checkOutput("en_off_gnt", 32'(gnt), 32'd0);
        checkOutput("en_off_ptr", 32'(ptr), 32'd3);
        en  = 1'b1;
        req = 4'b0101;
        applyStimulus("en_on");
        checkOutput("en_on_gnt", 32'(gnt), 32'b0001);

        // lone owner is never forced off
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            applyStimulus("lone");
            checkOutput("lone_gnt", 32'(gnt), 32'b0100);
        end

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            req = 4'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b0;
                #1;
                m_reset();
                checkModel("rand_reset");
                #1 reset_n = 1'b1;
            end
            applyStimulus("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rps_arbiter

// File: doc/rps_arbiter.md
RPS_ARBITER -- requirements
Module: rps_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters; power of two, N >= 2.
REQ-002 Parameter MAX_HOLD, default 4, maximum cycles one owner keeps the grant while others wait; 0 disables the limit.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  arbitration enable.
REQ-006 req  input  N  request lines, one per requester.
REQ-007 mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-008 gnt  output  N  registered grant; one-hot or all-zero.
REQ-009 gnt_idx  output  $clog2(N)  index of the set gnt bit; 0 when gnt_valid = 0.
REQ-010 gnt_valid  output  1  high when gnt is non-zero.
REQ-011 ptr  output  $clog2(N)  current round-robin priority pointer.

Function
REQ-012 The FSM SHALL have two states: IDLE (no owner) and BUSY (owner held in a register).
REQ-013 Winner search SHALL scan req from index ptr upward, wrapping modulo N, when mode = 0, and from index 0 upward when mode = 1.
REQ-014 IDLE with en = 1 and req != 0 SHALL register the search winner in gnt and enter BUSY at the next edge (1-cycle req-to-gnt latency).
REQ-015 BUSY with req[owner] = 1 and the hold limit not reached SHALL keep gnt unchanged.
REQ-016 BUSY with req[owner] = 0 SHALL re-arbitrate in the same cycle: the new winner appears at the next edge with no idle bubble; with no requests pending the FSM SHALL go to IDLE and gnt = 0.
REQ-017 hold_cnt SHALL clear on every new grant and increment each BUSY cycle with an unchanged owner, saturating at MAX_HOLD-1.
REQ-018 When MAX_HOLD > 0, hold_cnt = MAX_HOLD-1, and any non-owner request is high, the arbiter SHALL re-arbitrate with the owner excluded.
REQ-019 When the hold limit is reached and no other request is pending, the owner SHALL keep the grant.
REQ-020 On each new grant to index k with mode = 0, ptr SHALL load (k+1) mod N; with mode = 1, ptr SHALL hold.
REQ-021 en = 0 SHALL clear gnt and force IDLE at the next edge; ptr SHALL hold; req SHALL be ignored.
REQ-022 A change of mode SHALL take effect at the next arbitration decision and SHALL NOT revoke the current grant.
REQ-023 gnt, gnt_idx and gnt_valid SHALL be driven from registers only, with no combinational path from req.

Reset
REQ-024 While reset_n = 0, the block SHALL immediately, without waiting for a clock edge, set gnt = 0, gnt_idx = 0, gnt_valid = 0, ptr = 0, hold_cnt = 0 and state = IDLE.
REQ-025 The first arbitration SHALL happen on the first rising edge after reset_n deasserts.
REQ-026 Reset asserted mid-grant SHALL drop the grant with no completion cycle.

Structure
REQ-027 Package rps_pkg SHALL hold the state enum (IDLE, BUSY) and the default values of N and MAX_HOLD.
REQ-028 Sub-module rps_pick SHALL be the combinational rotating first-one finder, with inputs req, start index and exclude mask, and outputs one-hot, index and found.
REQ-029 The top level SHALL contain the FSM, hold_cnt, ptr and the output registers.

Verification (N=4, MAX_HOLD=4)
REQ-030 Reset: pulse reset_n low mid-BUSY -> gnt = 0000, gnt_valid = 0 and ptr = 0 without a clock edge.
REQ-031 Fairness: mode = 0, req = 1111 held -> gnt sequence 0001x4, 0010x4, 0100x4, 1000x4, 0001, with ptr = 1, 2, 3, 0.
REQ-032 Handoff: owner 0 with req = 0011, then drop req[0] -> gnt = 0010 on the next edge with no zero cycle.
REQ-033 Fixed mode: mode = 1, req = 1010 -> gnt = 0010 for 4 cycles, then 1000, then 0010 after req[3] drops; ptr unchanged throughout.
REQ-034 Enable: en = 0 during owner 2 -> gnt = 0000 next edge and ptr = 3 held; en = 1 with req = 0101 -> gnt = 0001.
REQ-035 Lone owner: req = 0100 only for 10 cycles -> gnt = 0100 continuously, no forced release.
